// File: rtl/mini_src_ctrl.sv
// mini_src_ctrl: multi-cycle control sequencer for the single-bus RISC datapath.
// Fetches an instruction over T0-T2, then decodes ir over T3-T7 and drives every
// bus-source, register-load, memory and ALU strobe for the current step.
// Optional build macro: MINI_SRC_CTRL_ILLEGAL_TRAP_EN -- when defined, unlisted
// opcodes trap to HALT and raise `illegal`; otherwise they execute as nop.
// FSM state is fully visible on `step`, `busy` and `halted`.
module mini_src_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_W       = 5
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] ir,
    input  logic                  con_ff,
    output logic                  pc_out,
    output logic                  pc_in,
    output logic                  inc_pc,
    output logic                  mar_in,
    output logic                  mdr_in,
    output logic                  mdr_out,
    output logic                  ir_in,
    output logic                  y_in,
    output logic                  z_in,
    output logic                  zlow_out,
    output logic                  c_out,
    output logic                  con_in,
    output logic                  read,
    output logic                  write,
    output logic                  gra,
    output logic                  grb,
    output logic                  grc,
    output logic                  r_in,
    output logic                  r_out,
    output logic                  ba_out,
    output logic [OP_W-1:0]       alu_op,
    output logic [2:0]            step,
    output logic                  busy,
    output logic                  halted,
    output logic                  illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [OP_W-1:0] OPC_LD   = OP_W'(0);
    localparam logic [OP_W-1:0] OPC_LDI  = OP_W'(1);
    localparam logic [OP_W-1:0] OPC_ST   = OP_W'(2);
    localparam logic [OP_W-1:0] OPC_R_LO = OP_W'(3);
    localparam logic [OP_W-1:0] OPC_R_HI = OP_W'(11);
    localparam logic [OP_W-1:0] OPC_ADDI = OP_W'(12);
    localparam logic [OP_W-1:0] OPC_ANDI = OP_W'(13);
    localparam logic [OP_W-1:0] OPC_ORI  = OP_W'(14);
    localparam logic [OP_W-1:0] OPC_BR   = OP_W'(18);
    localparam logic [OP_W-1:0] OPC_NOP  = OP_W'(26);
    localparam logic [OP_W-1:0] OPC_HALT = OP_W'(27);

    // ALU codes used for address / immediate / branch-target arithmetic
    localparam logic [OP_W-1:0] ALU_ADD  = OP_W'(3);
    localparam logic [OP_W-1:0] ALU_AND  = OP_W'(5);
    localparam logic [OP_W-1:0] ALU_OR   = OP_W'(6);

    state_t          state;
    logic [OP_W-1:0] op;
    logic            is_r, is_imm, is_ld, is_ldi, is_st, is_br, is_nop, is_halt;
    logic            is_listed, is_mem, nop_like, go_halt, last_step;
    logic            unused_ir;

    // Only the opcode field steers sequencing; operand fields go to the datapath.
    assign unused_ir = ^ir[DATA_WIDTH-OP_W-1:0];

    // Opcode classification from the live ir (meaningful from T3 onward)
    always_comb begin
        op        = ir[DATA_WIDTH-1 -: OP_W];
        is_r      = (op >= OPC_R_LO) && (op <= OPC_R_HI);
        is_imm    = (op >= OPC_ADDI) && (op <= OPC_ORI);
        is_ld     = (op == OPC_LD);
        is_ldi    = (op == OPC_LDI);
        is_st     = (op == OPC_ST);
        is_br     = (op == OPC_BR);
        is_nop    = (op == OPC_NOP);
        is_halt   = (op == OPC_HALT);
        is_mem    = is_ld || is_ldi || is_st;
        is_listed = is_r || is_imm || is_mem || is_br || is_nop || is_halt;
`ifdef MINI_SRC_CTRL_ILLEGAL_TRAP_EN
        nop_like  = is_nop;
        go_halt   = is_halt || !is_listed;
`else
        nop_like  = is_nop || !is_listed;
        go_halt   = is_halt;
`endif
    end

`ifdef MINI_SRC_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky trap flag: set when an unlisted opcode is decoded in T3, cleared only by clear
    always_ff @(posedge clock) begin
        if (clear) begin
            illegal_q <= 1'b0;
        end else if (state == S_T3 && !is_listed) begin
            illegal_q <= 1'b1;
        end
    end
`endif

    // Control decode of state and ir; everything forced to 0 while clear is high
    always_comb begin
        pc_out    = 1'b0;
        pc_in     = 1'b0;
        inc_pc    = 1'b0;
        mar_in    = 1'b0;
        mdr_in    = 1'b0;
        mdr_out   = 1'b0;
        ir_in     = 1'b0;
        y_in      = 1'b0;
        z_in      = 1'b0;
        zlow_out  = 1'b0;
        c_out     = 1'b0;
        con_in    = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        gra       = 1'b0;
        grb       = 1'b0;
        grc       = 1'b0;
        r_in      = 1'b0;
        r_out     = 1'b0;
        ba_out    = 1'b0;
        alu_op    = '0;
        step      = 3'd0;
        busy      = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        last_step = 1'b0;
        if (!clear) begin
            case (state)
                S_T0: begin
                    step = 3'd0; busy = 1'b1;
                    pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
                end
                S_T1: begin
                    step = 3'd1; busy = 1'b1;
                    zlow_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
                end
                S_T2: begin
                    step = 3'd2; busy = 1'b1;
                    mdr_out = 1'b1; ir_in = 1'b1;
                end
                S_T3: begin
                    step = 3'd3; busy = 1'b1;
                    last_step = nop_like;
                    if (is_br) begin
                        gra = 1'b1; r_out = 1'b1; con_in = 1'b1;
                    end else if (is_mem) begin
                        grb = 1'b1; ba_out = 1'b1; y_in = 1'b1;
                    end else if (is_r || is_imm) begin
                        grb = 1'b1; r_out = 1'b1; y_in = 1'b1;
                    end
                end
                S_T4: begin
                    step = 3'd4; busy = 1'b1;
                    if (is_br) begin
                        pc_out = 1'b1; y_in = 1'b1;
                    end else if (is_r) begin
                        grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = op;
                    end else begin
                        c_out = 1'b1; z_in = 1'b1;
                        if (op == OPC_ANDI)     alu_op = ALU_AND;
                        else if (op == OPC_ORI) alu_op = ALU_OR;
                        else                    alu_op = ALU_ADD;
                    end
                end
                S_T5: begin
                    step = 3'd5; busy = 1'b1;
                    last_step = !(is_ld || is_st || is_br);
                    if (is_br) begin
                        c_out = 1'b1; z_in = 1'b1; alu_op = ALU_ADD;
                    end else if (is_ld || is_st) begin
                        zlow_out = 1'b1; mar_in = 1'b1;
                    end else begin
                        zlow_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                    end
                end
                S_T6: begin
                    step = 3'd6; busy = 1'b1;
                    last_step = !(is_ld || is_st);
                    if (is_ld) begin
                        read = 1'b1; mdr_in = 1'b1;
                    end else if (is_st) begin
                        gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1;
                    end else begin
                        zlow_out = 1'b1; pc_in = con_ff;
                    end
                end
                S_T7: begin
                    step = 3'd7; busy = 1'b1;
                    last_step = 1'b1;
                    if (is_st) begin
                        write = 1'b1;
                    end else begin
                        mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                    end
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
`ifdef MINI_SRC_CTRL_ILLEGAL_TRAP_EN
            illegal = illegal_q;
`endif
        end
    end

    // Step sequencer: run is sampled only in IDLE and on an instruction's final step
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (run) state <= S_T0;
                S_HALT: state <= S_HALT;
                default: begin
                    if (state == S_T3 && go_halt) begin
                        state <= S_HALT;
                    end else if (last_step) begin
                        state <= run ? S_T0 : S_IDLE;
                    end else begin
                        state <= state_t'(state + 4'd1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mini_src_ctrl.sv
// Bench for mini_src_ctrl: directed instructions from the test plan plus a
// randomized instruction stream, checked cycle by cycle against a per-opcode
// table of expected strobe sets.
module tb_mini_src_ctrl;

    logic        clock = 1'b0;
    logic        clear, run, con_ff;
    logic [31:0] ir;
    logic        pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in;
    logic        zlow_out, c_out, con_in, read, write, gra, grb, grc, r_in, r_out, ba_out;
    logic [4:0]  alu_op;
    logic [2:0]  step;
    logic        busy, halted, illegal;

    int          errors = 0;
    int          checks = 0;
    logic [30:0] exp_q[$];
    bit          in_idle;

`ifdef MINI_SRC_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // strobe bit positions inside the packed observation word
    localparam logic [19:0] PC_OUT = 20'h80000, PC_IN = 20'h40000, INC_PC = 20'h20000;
    localparam logic [19:0] MAR_IN = 20'h10000, MDR_IN = 20'h08000, MDR_OUT = 20'h04000;
    localparam logic [19:0] IR_IN = 20'h02000, Y_IN = 20'h01000, Z_IN = 20'h00800;
    localparam logic [19:0] ZLOW_OUT = 20'h00400, C_OUT = 20'h00200, CON_IN = 20'h00100;
    localparam logic [19:0] READ = 20'h00080, WRITE = 20'h00040, GRA = 20'h00020;
    localparam logic [19:0] GRB = 20'h00010, GRC = 20'h00008, R_IN = 20'h00004;
    localparam logic [19:0] R_OUT = 20'h00002, BA_OUT = 20'h00001;

    mini_src_ctrl dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .con_ff(con_ff),
        .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
        .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
        .zlow_out(zlow_out), .c_out(c_out), .con_in(con_in), .read(read), .write(write),
        .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
        .alu_op(alu_op), .step(step), .busy(busy), .halted(halted), .illegal(illegal)
    );

    always #5 clock = ~clock;

    function automatic logic [30:0] obs();
        return {pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in,
                zlow_out, c_out, con_in, read, write, gra, grb, grc, r_in, r_out,
                ba_out, alu_op, step, busy, halted, illegal};
    endfunction

    task automatic check(input string tag, input logic [30:0] got, input logic [30:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one expected busy cycle; the step number is the position in the sequence
    task automatic push(input logic [19:0] s, input logic [4:0] a);
        logic [2:0] t;
        t = 3'(exp_q.size());
        exp_q.push_back({s, a, t, 1'b1, 2'b00});
    endtask

    // Reference: expected strobe set for every step of one instruction
    task automatic build_model(input logic [4:0] op, input logic con,
                               output bit to_halt, output bit trap);
        exp_q.delete();
        to_halt = 1'b0;
        trap    = 1'b0;
        push(PC_OUT | MAR_IN | INC_PC | Z_IN, 5'd0);
        push(ZLOW_OUT | PC_IN | READ | MDR_IN, 5'd0);
        push(MDR_OUT | IR_IN, 5'd0);
        if (op >= 5'd3 && op <= 5'd11) begin
            push(GRB | R_OUT | Y_IN, 5'd0);
            push(GRC | R_OUT | Z_IN, op);
            push(ZLOW_OUT | GRA | R_IN, 5'd0);
        end else if (op >= 5'd12 && op <= 5'd14) begin
            push(GRB | R_OUT | Y_IN, 5'd0);
            push(C_OUT | Z_IN, (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6);
            push(ZLOW_OUT | GRA | R_IN, 5'd0);
        end else if (op <= 5'd2) begin
            push(GRB | BA_OUT | Y_IN, 5'd0);
            push(C_OUT | Z_IN, 5'd3);
            if (op == 5'd1) begin
                push(ZLOW_OUT | GRA | R_IN, 5'd0);
            end else begin
                push(ZLOW_OUT | MAR_IN, 5'd0);
                if (op == 5'd0) begin
                    push(READ | MDR_IN, 5'd0);
                    push(MDR_OUT | GRA | R_IN, 5'd0);
                end else begin
                    push(GRA | R_OUT | MDR_IN, 5'd0);
                    push(WRITE, 5'd0);
                end
            end
        end else if (op == 5'd18) begin
            push(GRA | R_OUT | CON_IN, 5'd0);
            push(PC_OUT | Y_IN, 5'd0);
            push(C_OUT | Z_IN, 5'd3);
            push(ZLOW_OUT | (con ? PC_IN : 20'h0), 5'd0);
        end else if (op == 5'd26) begin
            push(20'h0, 5'd0);
        end else if (op == 5'd27) begin
            push(20'h0, 5'd0);
            to_halt = 1'b1;
        end else begin
            push(20'h0, 5'd0);
            if (TRAP) begin
                to_halt = 1'b1;
                trap    = 1'b1;
            end
        end
    endtask

    // leave IDLE: run is raised while IDLE outputs are still all zero
    task automatic start_from_idle(input string name);
        clear = 1'b0;
        run   = 1'b1;
        #1 check({name, "_idle"}, obs(), 31'h0);
        @(negedge clock);
    endtask

    task automatic exec_instr(input string name, input logic [31:0] instr,
                              input logic con, input logic run_end);
        bit          th, tr;
        int          n;
        logic [30:0] e;
        if (in_idle) start_from_idle(name);
        build_model(instr[31:27], con, th, tr);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            ir     = instr;
            con_ff = con;
            run    = (k == n - 1) ? run_end : 1'($urandom_range(0, 1));
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s_t%0d", name, k), obs(), e);
            @(negedge clock);
        end
        if (th) begin
            for (int k = 0; k < 4; k++) begin
                run = 1'($urandom_range(0, 1));
                #1 check($sformatf("%s_halt%0d", name, k), obs(), {29'h0, 1'b1, tr});
                @(negedge clock);
            end
            clear = 1'b1;
            #1 check({name, "_clear"}, obs(), 31'h0);
            @(negedge clock);
            clear = 1'b0;
            run   = 1'b0;
            #1 check({name, "_after_clear"}, obs(), 31'h0);
            @(negedge clock);
            in_idle = 1'b1;
        end else if (!run_end) begin
            run = 1'b0;
            #1 check({name, "_end_idle"}, obs(), 31'h0);
            @(negedge clock);
            in_idle = 1'b1;
        end else begin
            in_idle = 1'b0;
        end
    endtask

    // st interrupted by clear in T4: write must never appear, IDLE follows
    task automatic clear_mid_st();
        bit          th, tr;
        logic [30:0] e;
        if (in_idle) start_from_idle("stclr");
        build_model(5'd2, 1'b0, th, tr);
        for (int k = 0; k < 4; k++) begin
            ir  = 32'h10900010;
            run = 1'b1;
            #1;
            e = exp_q.pop_front();
            check($sformatf("stclr_t%0d", k), obs(), e);
            @(negedge clock);
        end
        clear = 1'b1;
        #1 check("stclr_t4_cleared", obs(), 31'h0);
        @(negedge clock);
        clear = 1'b0;
        run   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("stclr_idle%0d", k), obs(), 31'h0);
            @(negedge clock);
        end
        in_idle = 1'b1;
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] instr;
        bit          unl;
        clear   = 1'b1;
        run     = 1'b1;
        con_ff  = 1'b0;
        ir      = $urandom;
        in_idle = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("reset%0d", k), obs(), 31'h0);
            @(negedge clock);
        end
        clear = 1'b0;
        run   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1 check($sformatf("idle%0d", k), obs(), 31'h0);
            @(negedge clock);
        end
        in_idle = 1'b1;

        exec_instr("add",   32'h18918000, 1'b0, 1'b1);
        exec_instr("ld",    32'h00900010, 1'b0, 1'b1);
        exec_instr("br_c0", 32'h90800000, 1'b0, 1'b1);
        exec_instr("br_c1", 32'h90800000, 1'b1, 1'b1);
        exec_instr("st",    32'h10900010, 1'b0, 1'b1);
        exec_instr("addi",  32'h60900005, 1'b0, 1'b1);
        exec_instr("ori",   32'h70900005, 1'b0, 1'b1);
        exec_instr("ldi",   32'h08800007, 1'b0, 1'b0);
        exec_instr("nop",   32'hD0000000, 1'b0, 1'b1);
        exec_instr("unl",   32'hF8000000, 1'b0, 1'b0);
        clear_mid_st();

        for (int i = 0; i < 40; i++) begin
            op  = 5'($urandom_range(0, 31));
            unl = (op >= 5'd15 && op <= 5'd17) || (op >= 5'd19 && op <= 5'd25) || (op >= 5'd28);
            if (op == 5'd27) op = 5'd26;
            if (TRAP && unl) op = 5'd3;
            instr = {op, 27'($urandom)};
            exec_instr($sformatf("rnd%0d", i), instr, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
        end

        exec_instr("halt", 32'hD8000000, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mini_src_ctrl.md
# mini_src_ctrl

- Multi-cycle control sequencer for the single-bus RISC datapath: register file with hard-zero R0, PC, IR, MAR/MDR, Y/Z, and the ALU.
- Fetches an instruction, then decodes IR over a fixed sequence of one-cycle steps (T0–T7).
- Drives every bus-source, register-load, memory and ALU control strobe.
- Sits between the top-level run/halt interface and the datapath's select/encode logic.

## Interface
- `DATA_WIDTH`, 32: IR width.
- `OP_W`, 5: opcode field width; opcode is `ir[31:27]`.

Ports:
- `clock`, in, 1: sole clock; all state changes on its rising edge.
- `clear`, in, 1: synchronous active-high reset. While high, all control outputs are 0. At the edge, state becomes IDLE.
- `run`, in, 1: level; start/continue execution.
- `ir`, in, DATA_WIDTH: instruction register contents, valid from T3 onward.
- `con_ff`, in, 1: branch condition flip-flop output.
- `pc_out`, `pc_in`, `inc_pc`, `mar_in`, `mdr_in`, `mdr_out`, `ir_in`, `y_in`, `z_in`, `zlow_out`, `c_out`, `con_in`: out, 1: datapath strobes.
- `read`, `write`: out, 1: memory strobes.
- `gra`, `grb`, `grc`, `r_in`, `r_out`, `ba_out`: out, 1: register-file select and encode controls.
- `alu_op`, out, OP_W: ALU operation code. It is 0 except during compute steps.
- `step`, out, 3: current T-step (0–7); 0 when IDLE or HALT.
- `busy`, out, 1: high in T0–T7.
- `halted`, out, 1: high in HALT.
- `illegal`, out, 1: see Configuration.

## Operation
- States: IDLE, T0–T7, HALT.
- State is registered. Outputs are a combinational decode of state and `ir`, gated to 0 by `clear`.
- IDLE:
  - `run`=1 → T0.
  - Otherwise stay in IDLE.
- Fetch:
  - T0: `pc_out`, `mar_in`, `inc_pc`, `z_in`.
  - T1: `zlow_out`, `pc_in`, `read`, `mdr_in`.
  - T2: `mdr_out`, `ir_in`.
- Execute by opcode:
  - R-type, 00011–01011:
    - T3: `grb`, `r_out`, `y_in`.
    - T4: `grc`, `r_out`, `z_in`, `alu_op`=opcode.
    - T5: `zlow_out`, `gra`, `r_in`.
  - addi/andi/ori, 01100/01101/01110:
    - T3: same as R-type.
    - T4: `c_out`, `z_in`, `alu_op` = 00011/00101/00110.
    - T5: same as R-type.
  - ld 00000:
    - T3: `grb`, `ba_out`, `y_in`.
    - T4: `c_out`, `z_in`, `alu_op`=00011.
    - T5: `zlow_out`, `mar_in`.
    - T6: `read`, `mdr_in`.
    - T7: `mdr_out`, `gra`, `r_in`.
  - ldi 00001: T3–T4 as ld; T5: `zlow_out`, `gra`, `r_in`.
  - st 00010:
    - T3–T5: as ld.
    - T6: `gra`, `r_out`, `mdr_in`.
    - T7: `write`.
  - branch 10010:
    - T3: `gra`, `r_out`, `con_in`.
    - T4: `pc_out`, `y_in`.
    - T5: `c_out`, `z_in`, `alu_op`=00011.
    - T6: `zlow_out`, plus `pc_in` only if `con_ff`=1.
  - nop 11010: T3 has no strobes.
  - halt 11011: T3 → HALT.
- The last step of each sequence goes to T0 if `run`=1, else to IDLE.
- `run` dropping mid-instruction never aborts the instruction.
- HALT is left only by `clear`. `run` is ignored in HALT.

## Timing
- Every step lasts exactly one cycle. There are no wait states, and memory completes within a step.
- Instruction latency in cycles, including 3 fetch cycles:
  - R-type and immediate: 6.
  - ld, st: 8.
  - ldi: 6.
  - branch: 7.
  - nop: 4.
- `run` is sampled only in IDLE and on the final step of an instruction.
- IR loads at the end of T2, so decode uses `ir` from T3 onward. `ir` must be stable T3 through the final step.
- `clear` mid-instruction: strobes are 0 that cycle and state is IDLE next cycle. Partial register writes do not occur, because `r_in` is gated.
- Reset values: all strobes 0, `alu_op`=0, `step`=0, `busy`=0, `halted`=0, `illegal`=0.

## Configuration
- `MINI_SRC_CTRL_ILLEGAL_TRAP_EN` defined:
  - Any opcode not listed above goes from T3 to HALT.
  - `illegal`=1, held until `clear`.
- Undefined:
  - An unlisted opcode executes as nop.
  - `illegal` is tied to 0.

## Test plan
- clear, then `run`=1, `ir`=0x18918000 (add r1,r2,r3) → T0–T5 strobes as specified; `alu_op`=00011 in T4 only; back to T0 after 6 cycles.
- `ir`=0x00900010 (ld r1,0x10(r2)) → `ba_out` in T3; `read`+`mdr_in` in T6; `gra`+`r_in` in T7; 8 cycles total.
- `ir`=0x90800000 (branch) with `con_ff`=0 then 1 → `pc_in` absent then present in T6.
- `ir`=0xD8000000 (halt) → `halted`=1 after T3; `run` toggling is ignored; `clear` returns to IDLE with all outputs 0.
- `ir`=0xF8000000 → with macro: HALT, `illegal`=1. Without macro: 4-cycle nop.
- `clear` asserted in T4 of st → `write` never asserts; state is IDLE next cycle; `run` dropped during an instruction ends in IDLE after the final step.
